// File: rtl/lut_eval_seq.sv
// lut_eval_seq: clocked, run-time reprogrammable N_IN-input boolean function.
// The truth table lives in a 2**N_IN-bit register; each in_valid vector returns
// the indexed table bit one cycle later. A serial load port (bit 0 first)
// fills a shadow register that is committed to the table in a single cycle.
// Optional build macro: LUT_READBACK_EN adds the table_q readback port.
module lut_eval_seq #(
   parameter int                    N_IN = 3,
   parameter logic [(1<<N_IN)-1:0]  INIT = 8'h6D
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [N_IN-1:0]        in_bits,
   output logic                   out_valid,
   output logic                   out_bit,
   input  logic                   load_start,
   input  logic                   load_valid,
   input  logic                   load_bit,
   output logic                   load_busy,
   output logic                   load_done
`ifdef LUT_READBACK_EN
   ,
   output logic [(1<<N_IN)-1:0]   table_q
`endif
);

   localparam int DEPTH = 1 << N_IN;
   localparam int CNT_W = N_IN + 1;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [DEPTH-1:0]   shadow_reg, shadow_next;
   logic [DEPTH-1:0]   table_reg, table_next;
   logic               out_valid_reg, out_valid_next;
   logic               out_bit_reg, out_bit_next;
   logic               load_done_reg, load_done_next;

   // A data beat is a load_valid in LOAD that is not overridden by a restart.
   logic beat;
   logic last_beat;

   assign beat      = (state_reg == LOAD) && load_valid && !load_start;
   assign last_beat = beat && (count_reg == CNT_W'(DEPTH - 1));

   // Shadow bits: cleared by any load_start, otherwise the bit addressed by the
   // beat counter captures load_bit. Unwritten bits stay zero until commit.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shadow
         assign shadow_next[gi] = load_start ? 1'b0 :
                                  (beat && (count_reg[N_IN-1:0] == N_IN'(gi))) ? load_bit :
                                  shadow_reg[gi];
      end
   endgenerate

   // Next-state, evaluation and commit logic.
   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      table_next     = table_reg;
      out_valid_next = 1'b0;
      out_bit_next   = out_bit_reg;
      load_done_next = 1'b0;
      case (state_reg)
         RUN: begin
            // Evaluation uses the table as it stands, even if a load starts now.
            if (in_valid) begin
               out_valid_next = 1'b1;
               out_bit_next   = table_reg[in_bits];
            end
            if (load_start) begin
               state_next = LOAD;
               count_next = '0;
            end
         end
         LOAD: begin
            // in_valid is dropped here; out_valid stays low.
            if (load_start) begin
               count_next = '0;
            end else if (load_valid) begin
               count_next = count_reg + 1'b1;
               if (last_beat) begin
                  table_next            = shadow_reg;
                  table_next[DEPTH-1]   = load_bit;
                  state_next            = RUN;
                  load_done_next        = 1'b1;
               end
            end
         end
         default: state_next = RUN;
      endcase
   end

   // State and datapath registers; reset restores INIT and drops any partial load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= RUN;
         count_reg     <= '0;
         shadow_reg    <= '0;
         table_reg     <= INIT;
         out_valid_reg <= 1'b0;
         out_bit_reg   <= 1'b0;
         load_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         shadow_reg    <= shadow_next;
         table_reg     <= table_next;
         out_valid_reg <= out_valid_next;
         out_bit_reg   <= out_bit_next;
         load_done_reg <= load_done_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_bit   = out_bit_reg;
   assign load_busy = (state_reg == LOAD);
   assign load_done = load_done_reg;

`ifdef LUT_READBACK_EN
   assign table_q = table_reg;
`endif

endmodule

// File: tb/tb_lut_eval_seq.sv
// tb_lut_eval_seq: directed test of lut_eval_seq (N_IN=3, INIT=8'h6D).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_lut_eval_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_bits;
   logic       out_valid;
   logic       out_bit;
   logic       load_start;
   logic       load_valid;
   logic       load_bit;
   logic       load_busy;
   logic       load_done;
`ifdef LUT_READBACK_EN
   logic [7:0] table_q;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   lut_eval_seq #(.N_IN(3), .INIT(8'h6D)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_bits    (in_bits),
      .out_valid  (out_valid),
      .out_bit    (out_bit),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_bit   (load_bit),
      .load_busy  (load_busy),
      .load_done  (load_done)
`ifdef LUT_READBACK_EN
      ,
      .table_q    (table_q)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one vector for one cycle, then check the registered result.
   task automatic eval(input logic [2:0] v, input logic exp_bit, input string tag);
      in_valid = 1'b1;
      in_bits  = v;
      tick();
      in_valid = 1'b0;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_bit"}, out_bit, exp_bit);
      $display("eval %s in_bits=%0d out_bit=%0b", tag, v, out_bit);
   endtask

   // One load beat; load_done must be high only after the final beat.
   task automatic beat(input logic b, input logic exp_done, input string tag);
      load_valid = 1'b1;
      load_bit   = b;
      tick();
      load_valid = 1'b0;
      chk({tag, "_done"}, load_done, exp_done);
      chk({tag, "_busy"}, load_busy, !exp_done);
      $display("beat %s bit=%0b done=%0b busy=%0b", tag, b, load_done, load_busy);
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("start_busy", load_busy, 1);
   endtask

   logic [7:0] v;
   logic [7:0] sweep_exp;

   initial begin
      rst = 1'b1; in_valid = 0; in_bits = 0;
      load_start = 0; load_valid = 0; load_bit = 0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_busy", load_busy, 0);
      chk("rst_done", load_done, 0);
`ifdef LUT_READBACK_EN
      chk("rst_table_q", table_q, 8'h6D);
`endif
      tick();
      rst = 1'b0;
      tick();

      // Back-to-back sweep of all vectors against INIT 8'h6D.
      sweep_exp = 8'b0110_1101;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_bits  = 3'(k);
         tick();
         chk("sweep_valid", out_valid, 1);
         chk("sweep_bit", out_bit, sweep_exp[k]);
         $display("sweep in_bits=%0d out_bit=%0b", k, out_bit);
      end
      in_bits = 3'd5;
      tick();
      in_valid = 1'b0;
      chk("sweep5_bit", out_bit, 1);
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_hold", out_bit, 1);

      // Plain load of 8'hA5.
      v = 8'hA5;
      start_load();
      for (int i = 0; i < 8; i++) beat(v[i], i == 7, "a5");
`ifdef LUT_READBACK_EN
      chk("a5_table_q", table_q, 8'hA5);
`endif
      tick();
      chk("a5_done_pulse", load_done, 0);
      eval(3'd0, 1'b1, "a5_0");
      eval(3'd1, 1'b0, "a5_1");
      eval(3'd7, 1'b1, "a5_7");

      // Load of 8'h3C with three stalls and one dropped vector.
      v = 8'h3C;
      start_load();
      for (int i = 0; i < 4; i++) beat(v[i], 1'b0, "3c");
      for (int s = 0; s < 3; s++) begin
         in_valid = (s == 1);
         in_bits  = 3'd2;
         tick();
         in_valid = 1'b0;
         chk("stall_valid", out_valid, 0);
         chk("stall_busy", load_busy, 1);
         chk("stall_done", load_done, 0);
      end
      for (int i = 4; i < 8; i++) beat(v[i], i == 7, "3c");
      chk("3c_no_late_valid", out_valid, 0);
      eval(3'd2, 1'b1, "3c_2");
      eval(3'd0, 1'b0, "3c_0");
      eval(3'd7, 1'b0, "3c_7");

      // Partial load of 8'hFF, restart (with an ignored beat), then full 8'h0F.
      start_load();
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, "ff");
      load_start = 1'b1;
      load_valid = 1'b1;
      load_bit   = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b0;
      chk("restart_busy", load_busy, 1);
      v = 8'h0F;
      for (int i = 0; i < 8; i++) beat(v[i], i == 7, "0f");
      eval(3'd3, 1'b1, "0f_3");
      eval(3'd4, 1'b0, "0f_4");
      eval(3'd7, 1'b0, "0f_7");

      // Async reset in the middle of a load of 8'h00.
      eval(3'd0, 1'b1, "pre_rst");
      start_load();
      for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, "00");
      chk("pre_rst_bit", out_bit, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_out_bit", out_bit, 0);
      chk("async_busy", load_busy, 0);
      chk("async_valid", out_valid, 0);
      chk("async_done", load_done, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_busy", load_busy, 0);
`ifdef LUT_READBACK_EN
      chk("post_rst_table_q", table_q, 8'h6D);
`endif
      eval(3'd0, 1'b1, "init_0");
      eval(3'd1, 1'b0, "init_1");

      // load_valid in RUN must be ignored.
      for (int i = 0; i < 8; i++) begin
         load_valid = 1'b1;
         load_bit   = 1'b0;
         tick();
         chk("run_lv_busy", load_busy, 0);
         chk("run_lv_done", load_done, 0);
      end
      load_valid = 1'b0;
      eval(3'd2, 1'b1, "run_lv_2");

      // Same-cycle evaluation and load_start: old table used, LOAD entered.
      in_valid   = 1'b1;
      in_bits    = 3'd5;
      load_start = 1'b1;
      tick();
      in_valid   = 1'b0;
      load_start = 1'b0;
      chk("same_valid", out_valid, 1);
      chk("same_bit", out_bit, 1);
      chk("same_busy", load_busy, 1);
      $display("same-cycle in_bits=5 out_bit=%0b busy=%0b", out_bit, load_busy);
      for (int i = 0; i < 8; i++) begin
`ifdef LUT_READBACK_EN
         chk("same_table_q_hold", table_q, 8'h6D);
`endif
         beat(1'b0, i == 7, "zero");
      end
`ifdef LUT_READBACK_EN
      chk("zero_table_q", table_q, 8'h00);
`endif
      eval(3'd5, 1'b0, "zero_5");
      eval(3'd0, 1'b0, "zero_0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Sequential, parametrised evaluator for an N_IN-input boolean function.
- The function is held as a 2**N_IN-bit truth-table register, reprogrammable at run time over a serial load port.
- Each input vector presented with in_valid produces the table bit indexed by that vector, registered one cycle later.
- Sits beside other combinational lab blocks as their programmable, clocked replacement.

Parameters:
- N_IN, default 3: number of function inputs; legal range 1..6.
- INIT, default 8'h6D (width 2**N_IN): truth table loaded at reset. Bit k is the output for input vector k, with in_bits[N_IN-1] as MSB.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input vector present this cycle.
- in_bits  input  N_IN  input vector; in_bits[N_IN-1] is the MSB.
- out_valid  output  1  one-cycle pulse; out_bit is valid.
- out_bit  output  1  registered function value.
- load_start  input  1  begin (or restart) a table load.
- load_valid  input  1  load_bit present this cycle.
- load_bit  input  1  serial table bit, bit 0 first.
- load_busy  output  1  high while in LOAD state.
- load_done  output  1  one-cycle pulse after a new table commits.

Behaviour:
- Reset (async, rst=1):
  - table <= INIT; state <= RUN; load count <= 0; shadow <= 0.
  - out_valid, out_bit, load_busy and load_done all 0.
  - Takes effect immediately without a clock edge and overrides any load in progress. A partial load is discarded and the table returns to INIT.
- FSM states: RUN and LOAD.
- RUN:
  - in_valid=1 at edge t gives out_valid=1 and out_bit=table[in_bits] at t+1. Latency is 1 cycle.
  - Back-to-back vectors give back-to-back results. There is no backpressure.
  - in_valid=0 gives out_valid=0 next cycle; out_bit holds its last value.
  - load_start=1 moves to LOAD: count <= 0, shadow <= 0, load_busy=1 from the next cycle.
  - If in_valid and load_start are both 1 in the same cycle, the vector is evaluated against the current (old) table and the FSM still enters LOAD.
- LOAD:
  - Each cycle with load_valid=1 does shadow[count] <= load_bit and count <= count+1.
  - count width is N_IN+1 bits so it reaches 2**N_IN without overflow.
  - On the beat where count == 2**N_IN-1:
    - table <= shadow with the final bit merged in;
    - state <= RUN; load_busy <= 0;
    - load_done pulses 1 for exactly one cycle.
  - The new table is used by any in_valid sampled on or after the first RUN cycle.
  - load_valid=0 cycles are stalls: no change, no timeout.
  - in_valid while in LOAD is dropped: out_valid=0 and no result is produced later.
  - load_start while in LOAD restarts: count <= 0, shadow <= 0, the table is unchanged, and any load_valid in that same cycle is ignored.
  - load_valid while in RUN is ignored.
- The table never changes except at load commit or reset. A partial load never alters it.

Optional Feature:
- Macro: LUT_READBACK_EN.
- When defined:
  - adds output port table_q, width 2**N_IN, which continuously reflects the committed table register;
  - equals INIT after reset and updates in the same cycle load_done rises.
- When undefined: the port is absent and no extra logic is generated. All other behaviour is identical.

Test Plan:
- Reset, then sweep in_bits 0..7 with in_valid held high on consecutive cycles. Required out_bit sequence one cycle later: 1,0,1,1,0,1,1,0 (8'h6D), with out_valid high for 8 cycles.
- load_start, then 8 load_valid beats of bits for 8'hA5 (LSB first: 1,0,1,0,0,1,0,1). Required: load_busy high throughout, load_done a single pulse, then in_bits=0 gives 1, in_bits=1 gives 0, in_bits=7 gives 1.
- During LOAD, insert 3 load_valid=0 stall cycles and one in_valid with in_bits=2. Required: out_valid stays 0; the load completes after the 8th valid beat; the table equals the loaded value.
- After 4 beats of a load, pulse load_start, then send the full 8'h0F. Required: table = 8'h0F, not a mix of the two loads; in_bits=3 gives 1 and in_bits=4 gives 0.
- Assert rst asynchronously mid-load, after 5 beats of 8'h00. Required: outputs are 0 immediately; after reset, in_bits=0 gives 1 (INIT restored); load_busy=0.
- Same-cycle in_valid with in_bits=5 and load_start in RUN with table 8'h6D. Required: out_valid=1 and out_bit=1 next cycle, with load_busy=1. With LUT_READBACK_EN defined, table_q = 8'h6D until the commit.
